// File: rtl/genesis_pad_scanner_if.sv
// Pin-side and result-side signals of the Genesis pad scanner.
// The master modport is the scanner itself; the slave modport is the pads plus consumer logic.
interface genesis_pad_scanner_if #(
    parameter int N_PADS = 1
);
    logic [6*N_PADS-1:0]  pad_pins;
    logic                 select_out;
    logic [11*N_PADS-1:0] buttons_held;
    logic [11*N_PADS-1:0] buttons_pressed;
    logic [N_PADS-1:0]    pad_present;
    logic [N_PADS-1:0]    six_btn_pad;
    logic                 frame_done;

    modport master (
        input  pad_pins,
        output select_out, buttons_held, buttons_pressed, pad_present, six_btn_pad, frame_done
    );

    modport slave (
        output pad_pins,
        input  select_out, buttons_held, buttons_pressed, pad_present, six_btn_pad, frame_done
    );
endinterface

// File: rtl/genesis_pad_scanner.sv
// Multi-pad SEGA Genesis reader: shared select sequencing, 3/6-button scan, per-button
// frame debounce, press pulses and optional D-pad auto-repeat.
module genesis_pad_scanner #(
    parameter int N_PADS          = 1,
    parameter int SIX_BTN         = 1,
    parameter int PHASE_CYCLES    = 500,
    parameter int FRAME_GAP       = 100000,
    parameter int DEBOUNCE_FRAMES = 2,
    parameter int REPEAT_EN       = 0,
    parameter int REPEAT_DELAY    = 15,
    parameter int REPEAT_PERIOD   = 5
) (
    input  logic                  clock_50,
    input  logic                  reset_key,
    genesis_pad_scanner_if.master pad
);
    localparam int K      = (SIX_BTN != 0) ? 8 : 2;
    localparam int PH_W   = $clog2(PHASE_CYCLES);
    localparam int GAP_W  = (FRAME_GAP > 1) ? $clog2(FRAME_GAP) : 1;
    localparam int DB_W   = $clog2(DEBOUNCE_FRAMES + 1);
    localparam int RP_MAX = REPEAT_DELAY + REPEAT_PERIOD;
    localparam int RP_W   = $clog2(RP_MAX + 1);

    typedef enum logic [1:0] {S_GAP, S_SCAN, S_COMMIT} state_t;

    state_t           state, state_nx;
    logic [GAP_W-1:0] gap_cnt, gap_nx;
    logic [PH_W-1:0]  ph_cnt, ph_nx;
    logic [2:0]       phase, phase_nx;
    logic             sample_p0;
    logic             commit_p1;
    logic             select_c;
    logic             frame_done_p2;

    always_ff @(posedge clock_50 or negedge reset_key) begin
        if (!reset_key) begin
            state         <= S_GAP;
            gap_cnt       <= '0;
            ph_cnt        <= '0;
            phase         <= '0;
            frame_done_p2 <= 1'b0;
        end else begin
            state         <= state_nx;
            gap_cnt       <= gap_nx;
            ph_cnt        <= ph_nx;
            phase         <= phase_nx;
            frame_done_p2 <= commit_p1;
        end
    end

    always_comb begin
        state_nx  = state;
        gap_nx    = gap_cnt;
        ph_nx     = ph_cnt;
        phase_nx  = phase;
        sample_p0 = 1'b0;
        commit_p1 = 1'b0;
        select_c  = 1'b1;
        case (state)
            S_GAP: begin
                if (gap_cnt == GAP_W'(FRAME_GAP - 1)) begin
                    state_nx = S_SCAN;
                    gap_nx   = '0;
                    ph_nx    = '0;
                    phase_nx = '0;
                end else begin
                    gap_nx = gap_cnt + GAP_W'(1);
                end
            end
            S_SCAN: begin
                // Odd phases drive select low; pins are sampled on the last clock of each phase
                select_c = ~phase[0];
                if (ph_cnt == PH_W'(PHASE_CYCLES - 1)) begin
                    sample_p0 = 1'b1;
                    ph_nx     = '0;
                    if (phase == 3'(K - 1)) state_nx = S_COMMIT;
                    else                    phase_nx = phase + 3'd1;
                end else begin
                    ph_nx = ph_cnt + PH_W'(1);
                end
            end
            S_COMMIT: begin
                commit_p1 = 1'b1;
                state_nx  = S_GAP;
                gap_nx    = '0;
            end
            default: state_nx = S_GAP;
        endcase
    end

    assign pad.select_out = select_c;
    assign pad.frame_done = frame_done_p2;

    for (genvar p = 0; p < N_PADS; p++) begin : g_pad
        logic [5:0]      pins;
        logic [10:0]     cap_p0;
        logic            present_p0;
        logic            six_p0;
        logic [10:0]     raw_p1;
        logic [10:0]     stable_p2, stable_nx;
        logic [10:0]     pressed_p2, press_nx;
        logic            present_p2, six_p2;
        logic [DB_W-1:0] db_cnt [11];
        logic [DB_W-1:0] db_nx  [11];
        logic [RP_W-1:0] rp_cnt [4];
        logic [RP_W-1:0] rp_nx  [4];
        logic [RP_W-1:0] rp_inc;

        assign pins = pad.pad_pins[6*p +: 6];

        // Absent pad reads as all-released so held bits decay through the debouncer
        always_comb begin
            raw_p1 = cap_p0;
            if (SIX_BTN == 0 || !six_p0) raw_p1[8:6] = 3'b000;
            if (!present_p0)             raw_p1      = '0;
        end

        always_comb begin
            stable_nx = stable_p2;
            rp_inc    = '0;
            for (int b = 0; b < 11; b++) begin
                db_nx[b] = db_cnt[b];
                if (raw_p1[b] == stable_p2[b]) begin
                    db_nx[b] = '0;
                end else if (db_cnt[b] == DB_W'(DEBOUNCE_FRAMES - 1)) begin
                    stable_nx[b] = raw_p1[b];
                    db_nx[b]     = '0;
                end else begin
                    db_nx[b] = db_cnt[b] + DB_W'(1);
                end
            end
            press_nx = stable_nx & ~stable_p2;
            for (int d = 0; d < 4; d++) begin
                rp_nx[d] = rp_cnt[d];
                if (REPEAT_EN != 0) begin
                    if (!stable_nx[d] || !stable_p2[d]) begin
                        rp_nx[d] = '0;
                    end else begin
                        rp_inc = (rp_cnt[d] == RP_W'(RP_MAX)) ? rp_cnt[d] : rp_cnt[d] + RP_W'(1);
                        if (rp_inc == RP_W'(RP_MAX)) begin
                            press_nx[d] = 1'b1;
                            rp_nx[d]    = RP_W'(REPEAT_DELAY);
                        end else begin
                            if (rp_inc == RP_W'(REPEAT_DELAY)) press_nx[d] = 1'b1;
                            rp_nx[d] = rp_inc;
                        end
                    end
                end
            end
        end

        always_ff @(posedge clock_50 or negedge reset_key) begin
            if (!reset_key) begin
                cap_p0     <= '0;
                present_p0 <= 1'b0;
                six_p0     <= 1'b0;
                stable_p2  <= '0;
                pressed_p2 <= '0;
                present_p2 <= 1'b0;
                six_p2     <= 1'b0;
                for (int b = 0; b < 11; b++) db_cnt[b] <= '0;
                for (int d = 0; d < 4; d++)  rp_cnt[d] <= '0;
            end else begin
                // Scan capture: pins are active-low
                if (sample_p0) begin
                    case (phase)
                        3'd0: begin
                            cap_p0[3:0] <= ~pins[3:0];
                            cap_p0[9]   <= ~pins[4];
                            cap_p0[10]  <= ~pins[5];
                        end
                        3'd1: begin
                            cap_p0[4]  <= ~pins[4];
                            cap_p0[5]  <= ~pins[5];
                            present_p0 <= (pins[3:2] == 2'b00);
                        end
                        3'd5: six_p0 <= (pins[3:0] == 4'b0000);
                        3'd6: cap_p0[8:6] <= ~pins[2:0];
                        default: ;
                    endcase
                end
                // Commit: debounce, edge and repeat results become visible next clock
                pressed_p2 <= '0;
                if (commit_p1) begin
                    stable_p2  <= stable_nx;
                    pressed_p2 <= press_nx;
                    present_p2 <= present_p0;
                    six_p2     <= (SIX_BTN != 0) && six_p0;
                    for (int b = 0; b < 11; b++) db_cnt[b] <= db_nx[b];
                    for (int d = 0; d < 4; d++)  rp_cnt[d] <= rp_nx[d];
                end
            end
        end

        assign pad.buttons_held[11*p +: 11]    = stable_p2;
        assign pad.buttons_pressed[11*p +: 11] = pressed_p2;
        assign pad.pad_present[p]              = present_p2;
        assign pad.six_btn_pad[p]              = six_p2;
    end
endmodule
